bram_arb: RTL and testbench

Two-port arbiter that shares the single-ported `bram` between the core's instruction-fetch port (m0, read-only) and its load/store port (m1, read/write with byte enables). It sits between the core and `bram`. It serialises requests with round-robin priority and routes each 1-cycle-latency read response back to its owner. It turns sub-word stores into read-modify-write sequences, because `bram` only writes full 32-bit words.

---
 rtl/bram_arb.sv | 175 +++++++++++++++++
 tb/tb_bram_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arb.sv
// bram_arb: round-robin arbiter sharing one single-port bram between fetch (m0) and load/store (m1).
// Define BRAM_ARB_RMW_EN to turn sub-word stores into read-modify-write; otherwise they write the full word.
module bram_arb #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_req_i,
    input  logic [AW-1:0]   m0_addr_i,
    output logic            m0_gnt_o,
    output logic [DW-1:0]   m0_rd_data_o,
    output logic            m0_rd_valid_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_be_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wr_data_i,
    output logic            m1_gnt_o,
    output logic [DW-1:0]   m1_rd_data_o,
    output logic            m1_rd_valid_o,
    output logic            m1_done_o,
    output logic            mem_rd_en_o,
    output logic [AW-1:0]   mem_addr_o,
    input  logic [DW-1:0]   mem_rd_data_i,
    input  logic            mem_rd_valid_i,
    output logic            mem_wr_en_o,
    output logic [DW-1:0]   mem_wr_data_o
);
    localparam int BW = DW / 8;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

`ifdef BRAM_ARB_RMW_EN
    typedef enum logic {ISSUE, MERGE} state_t;
`else
    typedef enum logic {ISSUE} state_t;
`endif

    state_t state_q, state_d;
    logic   last_q, last_d;     // 1: m1 was granted most recently
    logic   pend_q, pend_d;     // a read is in flight this cycle
    logic   tag_q, tag_d;       // owner of the in-flight read, 1 = m1
    logic   done_q, done_d;
    logic   gnt0, gnt1;
`ifdef BRAM_ARB_RMW_EN
    logic            rmw_q, rmw_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   addr_q, addr_d;
`endif

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        pend_d        = 1'b0;
        tag_d         = tag_q;
        done_d        = 1'b0;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        m0_gnt_o      = 1'b0;
        m1_gnt_o      = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_wr_en_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
`ifdef BRAM_ARB_RMW_EN
        rmw_d         = 1'b0;
        be_d          = be_q;
        wdata_d       = wdata_q;
        addr_d        = addr_q;
`endif
        if (!rst_i) begin
            case (state_q)
                ISSUE: begin
                    if (m0_req_i && (!m1_req_i || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (m1_req_i) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0) begin
                        m0_gnt_o    = 1'b1;
                        last_d      = 1'b0;
                        mem_rd_en_o = 1'b1;
                        mem_addr_o  = m0_addr_i & WORD_MASK;
                        pend_d      = 1'b1;
                        tag_d       = 1'b0;
                    end
                    if (gnt1) begin
                        m1_gnt_o = 1'b1;
                        last_d   = 1'b1;
                        if (!m1_we_i) begin
                            mem_rd_en_o = 1'b1;
                            mem_addr_o  = m1_addr_i & WORD_MASK;
                            pend_d      = 1'b1;
                            tag_d       = 1'b1;
                        end else if (m1_be_i == '0) begin
                            done_d = 1'b1;
`ifdef BRAM_ARB_RMW_EN
                        end else if (m1_be_i != '1) begin
                            // read the old word now, merge it next cycle
                            mem_rd_en_o = 1'b1;
                            mem_addr_o  = m1_addr_i & WORD_MASK;
                            pend_d      = 1'b1;
                            tag_d       = 1'b1;
                            rmw_d       = 1'b1;
                            be_d        = m1_be_i;
                            wdata_d     = m1_wr_data_i;
                            addr_d      = m1_addr_i & WORD_MASK;
                            state_d     = MERGE;
`endif
                        end else begin
                            mem_wr_en_o   = 1'b1;
                            mem_addr_o    = m1_addr_i & WORD_MASK;
                            mem_wr_data_o = m1_wr_data_i;
                            done_d        = 1'b1;
                        end
                    end
                end
`ifdef BRAM_ARB_RMW_EN
                MERGE: begin
                    mem_wr_en_o = 1'b1;
                    mem_addr_o  = addr_q;
                    for (int i = 0; i < BW; i++) begin
                        mem_wr_data_o[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                                          : mem_rd_data_i[8*i +: 8];
                    end
                    done_d  = 1'b1;
                    state_d = ISSUE;
                end
`endif
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ISSUE;
            last_q  <= 1'b1;
            pend_q  <= 1'b0;
            tag_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef BRAM_ARB_RMW_EN
            rmw_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
`ifdef BRAM_ARB_RMW_EN
            rmw_q   <= rmw_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
`endif
        end
    end

    assign m0_rd_valid_o = !rst_i && pend_q && !tag_q && mem_rd_valid_i;
`ifdef BRAM_ARB_RMW_EN
    // the RMW read-back is consumed by the merge, not returned to m1
    assign m1_rd_valid_o = !rst_i && pend_q && tag_q && !rmw_q && mem_rd_valid_i;
`else
    assign m1_rd_valid_o = !rst_i && pend_q && tag_q && mem_rd_valid_i;
`endif
    assign m0_rd_data_o  = m0_rd_valid_o ? mem_rd_data_i : '0;
    assign m1_rd_data_o  = m1_rd_valid_o ? mem_rd_data_i : '0;
    assign m1_done_o     = !rst_i && done_q;

endmodule

// File: tb/tb_bram_arb.sv
// Testbench for bram_arb: bench-side bram, reference memory/round-robin model, directed vectors.
module tb_bram_arb;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NW = 2048;
`ifdef BRAM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_gnt, m0_rd_valid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_rd_data;
    logic          m1_req, m1_we, m1_gnt, m1_rd_valid, m1_done;
    logic [3:0]    m1_be;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wr_data, m1_rd_data;
    logic          mem_rd_en, mem_wr_en;
    logic          mem_rd_valid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] mem_wr_data;
    logic          preload;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    bram_arb #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
        .m0_rd_data_o(m0_rd_data), .m0_rd_valid_o(m0_rd_valid),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wr_data_i(m1_wr_data), .m1_gnt_o(m1_gnt), .m1_rd_data_o(m1_rd_data),
        .m1_rd_valid_o(m1_rd_valid), .m1_done_o(m1_done),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data),
        .mem_rd_valid_i(mem_rd_valid), .mem_wr_en_o(mem_wr_en), .mem_wr_data_o(mem_wr_data)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 'h41) return 32'hCAFE0104;
        if (i == 2)    return 32'h11223344;
        return 32'hA500_0000 | i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // single-port bram with 1-cycle read latency
    logic [31:0] bram_q [0:NW-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) bram_q[i] <= init_word(i);
        end else begin
            mem_rd_valid <= mem_rd_en;
            if (mem_rd_en) mem_rd_data <= bram_q[mem_addr[AW-1:2]];
            if (mem_wr_en) bram_q[mem_addr[AW-1:2]] <= mem_wr_data;
        end
    end

    // reference model: memory contents as the stores define them, plus expected events
    typedef struct { int due; bit port; logic [31:0] data; } resp_t;
    resp_t       rq[$];
    logic [31:0] ref_mem [0:NW-1];
    bit          m_last, m_merge;
    int          done_due, cyc;
    int          mg_idx;
    logic [3:0]  mg_be;
    logic [31:0] mg_data;

    initial begin
        bit e_g0, e_g1, e_v0, e_v1, e_rd, e_wr, part;
        logic [31:0] e_d, e_wd, merged;
        logic [AW-1:0] e_a;
        resp_t r;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        m_last = 1'b1; m_merge = 1'b0; done_due = -1; cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ctrl", {m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, m1_done, mem_rd_en, mem_wr_en}, 0);
                chk("rst_data", m0_rd_data | m1_rd_data | mem_wr_data | {19'b0, mem_addr}, 0);
                rq.delete();
                m_last = 1'b1; m_merge = 1'b0; done_due = -1;
            end else begin
                e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_d = '0; e_wd = '0; e_a = '0;
                part = m1_we && m1_be != 4'h0 && m1_be != 4'hF;
                if (!m_merge) begin
                    if (m0_req && m1_req) begin
                        e_g0 = m_last; e_g1 = !m_last;
                    end else begin
                        e_g0 = m0_req; e_g1 = m1_req;
                    end
                end
                e_rd = e_g0 || (e_g1 && (!m1_we || (RMW && part)));
                e_wr = m_merge || (e_g1 && m1_we && m1_be != 4'h0 && !(RMW && part));
                merged = '0;
                if (m_merge) begin
                    merged = ref_mem[mg_idx];
                    for (int b = 0; b < 4; b++) if (mg_be[b]) merged[8*b +: 8] = mg_data[8*b +: 8];
                    e_a = AW'(mg_idx * 4); e_wd = merged;
                end else if (e_g0) e_a = m0_addr & ~AW'(3);
                else if (e_g1) begin
                    e_a = m1_addr & ~AW'(3); e_wd = m1_wr_data;
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    r = rq.pop_front();
                    e_v0 = !r.port; e_v1 = r.port; e_d = r.data;
                end
                chk("gnt", {m0_gnt, m1_gnt}, {e_g0, e_g1});
                chk("mem_cmd", {mem_rd_en, mem_wr_en}, {e_rd, e_wr});
                if (e_rd || e_wr) chk("mem_addr", mem_addr, e_a);
                if (e_wr) chk("mem_wr_data", mem_wr_data, e_wd);
                chk("addr_lsb", mem_addr[1:0], 0);
                chk("rd_valid", {m0_rd_valid, m1_rd_valid}, {e_v0, e_v1});
                if (e_v0) chk("m0_rd_data", m0_rd_data, e_d);
                if (e_v1) chk("m1_rd_data", m1_rd_data, e_d);
                chk("m1_done", m1_done, done_due == cyc);
                if (m_merge) begin
                    ref_mem[mg_idx] = merged;
                    m_merge = 1'b0;
                end
                if (e_g0) begin
                    rq.push_back('{cyc + 1, 1'b0, ref_mem[m0_addr[AW-1:2]]});
                    m_last = 1'b0;
                end
                if (e_g1) begin
                    m_last = 1'b1;
                    if (!m1_we) rq.push_back('{cyc + 1, 1'b1, ref_mem[m1_addr[AW-1:2]]});
                    else if (RMW && part) begin
                        m_merge = 1'b1; mg_idx = int'(m1_addr[AW-1:2]);
                        mg_be = m1_be; mg_data = m1_wr_data; done_due = cyc + 2;
                    end else begin
                        if (m1_be != 4'h0) ref_mem[m1_addr[AW-1:2]] = m1_wr_data;
                        done_due = cyc + 1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic m1_set(input bit we, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] d);
        m1_req = 1'b1; m1_we = we; m1_be = be; m1_addr = a; m1_wr_data = d;
    endtask

    initial begin
        logic [3:0] gseq;
        int bad;
        rst = 1'b1; preload = 1'b1;
        m0_req = 0; m0_addr = '0; m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wr_data = '0;
        step(); preload = 1'b0;
        step(); rst = 1'b0;

        // fetch only
        m0_req = 1'b1; m0_addr = 13'h104;
        @(negedge clk);
        chk("fetch_gnt", m0_gnt, 1); chk("fetch_addr", mem_addr, 13'h104); chk("fetch_rd_en", mem_rd_en, 1);
        step(); m0_req = 1'b0;
        @(negedge clk);
        chk("fetch_valid", m0_rd_valid, 1); chk("fetch_data", m0_rd_data, 32'hCAFE0104);
        chk("fetch_m1_quiet", {m1_gnt, m1_rd_valid, m1_done}, 0);
        step();

        // contention right after reset: m0, m1, m0, m1
        rst = 1'b1; step(); rst = 1'b0;
        m0_req = 1'b1; m0_addr = 13'h000; m1_set(1'b0, 4'h0, 13'h004, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); gseq[k] = m1_gnt;
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("cont_order", gseq, 4'b1010);

        // full store then load back
        m1_set(1'b1, 4'hF, 13'h020, 32'hDEADBEEF);
        @(negedge clk); chk("fs_wr_en", mem_wr_en, 1); chk("fs_gnt", m1_gnt, 1);
        step(); m1_req = 1'b0;
        @(negedge clk); chk("fs_done", m1_done, 1);
        step(); m1_set(1'b0, 4'h0, 13'h020, '0);
        @(negedge clk); chk("ld_gnt", m1_gnt, 1);
        step(); m1_req = 1'b0;
        @(negedge clk); chk("ld_valid", m1_rd_valid, 1); chk("ld_data", m1_rd_data, 32'hDEADBEEF);
        step();

        // partial store, with m0 arriving in the following cycle
        m1_set(1'b1, 4'b0010, 13'h008, 32'h0000AA00);
        @(negedge clk); chk("ps_gnt", m1_gnt, 1);
        step(); m1_req = 1'b0; m0_req = 1'b1; m0_addr = 13'h104;
        @(negedge clk);
`ifdef BRAM_ARB_RMW_EN
        chk("ps_merge_no_m0", m0_gnt, 0); chk("ps_merge_wr", mem_wr_en, 1); chk("ps_done_early", m1_done, 0);
        step();
        @(negedge clk); chk("ps_done", m1_done, 1); chk("ps_m0_after", m0_gnt, 1);
`else
        chk("ps_done", m1_done, 1); chk("ps_m0_now", m0_gnt, 1);
`endif
        step(); m0_req = 1'b0; m1_set(1'b0, 4'h0, 13'h008, '0);
        @(negedge clk);
        step(); m1_req = 1'b0;
        @(negedge clk);
`ifdef BRAM_ARB_RMW_EN
        chk("ps_readback", m1_rd_data, 32'h1122AA44);
`else
        chk("ps_readback", m1_rd_data, 32'h0000AA00);
`endif
        step();

        // store with no byte enables
        m1_set(1'b1, 4'h0, 13'h030, 32'hFFFFFFFF);
        @(negedge clk); chk("z_gnt", m1_gnt, 1); chk("z_no_access", {mem_rd_en, mem_wr_en}, 0);
        step(); m1_req = 1'b0;
        @(negedge clk); chk("z_done", m1_done, 1);
        step();

        // reset right after a partial-store grant
        m1_set(1'b1, 4'b1000, 13'h00C, 32'h77000000);
        @(negedge clk); chk("rm_gnt", m1_gnt, 1);
        step(); m1_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("rm_no_wr", mem_wr_en, 0); chk("rm_no_done", m1_done, 0);
        step(); rst = 1'b0;
        @(negedge clk); chk("rm_no_done_after", m1_done, 0);
`ifdef BRAM_ARB_RMW_EN
        chk("rm_mem", bram_q[3], 32'hA5000003);
`else
        chk("rm_mem", bram_q[3], 32'h77000000);
`endif
        step();

        // reset with a fetch in flight
        m0_req = 1'b1; m0_addr = 13'h104;
        @(negedge clk); chk("rf_gnt", m0_gnt, 1);
        step(); m0_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("rf_drop", m0_rd_valid, 0);
        step(); rst = 1'b0;
        @(negedge clk); chk("rf_drop_after", m0_rd_valid, 0);
        step(); step();

        bad = 0;
        for (int i = 0; i < NW; i++) if (bram_q[i] !== ref_mem[i]) bad++;
        chk("final_mem_mismatches", bad, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
